// File: rtl/isqrt_arb_pkg.sv
// Shared types and helpers for the isqrt round-robin arbiter.
//   MAX_CLIENTS : upper bound on the number of requesters
//   client_id_t : client index wide enough for MAX_CLIENTS
//   rr_pick()   : round-robin search returning {found, id}
package isqrt_arb_pkg;

  localparam int MAX_CLIENTS = 16;

  typedef logic [3:0] client_id_t;

  typedef struct packed {
    logic       found;
    client_id_t id;
  } rr_pick_t;

  // Searches ptr, ptr+1, ... wrapping over all MAX_CLIENTS positions.
  // Callers zero the request bits above their own client count, so the
  // wrap over 16 positions visits real clients in the same order as a
  // wrap over N_CLIENTS would.
  function automatic rr_pick_t rr_pick(input logic [MAX_CLIENTS-1:0] req,
                                       input client_id_t ptr);
    rr_pick_t   r;
    client_id_t idx;
    r = '0;
    for (int i = 0; i < MAX_CLIENTS; i++) begin
      idx = ptr + client_id_t'(i);
      if (!r.found && req[idx]) begin
        r.found = 1'b1;
        r.id    = idx;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/isqrt_tag_fifo.sv
// In-order tag FIFO: remembers which client issued each in-flight isqrt
// request so the result can be routed back.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data (ignored when full unless popping too)
//   push_data  : tag to store
//   pop        : remove the oldest entry (ignored when empty)
//   pop_data   : oldest entry, valid whenever empty is low
//   full/empty : occupancy flags
// Storage is a small LUT RAM with asynchronous read so the head tag is
// usable in the same cycle as the pop.
module isqrt_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign do_pop   = pop & ~empty;
  // A full FIFO can still accept a push when an entry leaves this cycle.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/isqrt_rr_arbiter.sv
// Shares one pipelined isqrt among N_CLIENTS requesters.
//   clk, rst     : clock, synchronous active-high reset
//   req_vld      : per-client request valid
//   req_x        : per-client radicand, client i at [32*i +: 32]
//   req_rdy      : one-hot combinational grant
//   rsp_vld      : one-hot registered result strobe
//   rsp_y        : result for the client flagged in rsp_vld
//   isqrt_x_vld  : registered issue strobe to the isqrt
//   isqrt_x      : registered radicand to the isqrt
//   isqrt_y_vld  : isqrt result strobe (results return in issue order)
//   isqrt_y      : isqrt result
//   err_orphan   : sticky, a result arrived with no tag outstanding
module isqrt_rr_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int TAG_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CLIENTS-1:0]    req_vld,
  input  logic [N_CLIENTS*32-1:0] req_x,
  output logic [N_CLIENTS-1:0]    req_rdy,
  output logic [N_CLIENTS-1:0]    rsp_vld,
  output logic [15:0]             rsp_y,
  output logic                    isqrt_x_vld,
  output logic [31:0]             isqrt_x,
  input  logic                    isqrt_y_vld,
  input  logic [15:0]             isqrt_y,
  output logic                    err_orphan
);

  localparam int TW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  client_id_t             ptr_reg;
  client_id_t             ptr_next;
  logic [MAX_CLIENTS-1:0] req_ext;
  rr_pick_t               pick;
  logic [31:0]            sel_x;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [TW-1:0]          pop_tag;
  logic                   pop_ok;
  logic                   issue_ok;
  logic                   transfer;
  logic [N_CLIENTS-1:0]   rsp_vld_next;

  always_comb begin
    req_ext = '0;
    req_ext[N_CLIENTS-1:0] = req_vld;
  end

  assign pick = rr_pick(req_ext, ptr_reg);

  // Popping frees a slot in the same cycle, so a full FIFO may still issue.
  assign pop_ok   = isqrt_y_vld & ~fifo_empty;
  assign issue_ok = ~fifo_full | pop_ok;
  assign transfer = ~rst & issue_ok & pick.found;

  assign ptr_next = (pick.id == client_id_t'(N_CLIENTS - 1)) ? '0
                                                               : pick.id + 4'd1;

  genvar gi;
  generate
    for (gi = 0; gi < N_CLIENTS; gi++) begin : g_client
      assign req_rdy[gi]      = transfer & (pick.id == client_id_t'(gi));
      assign rsp_vld_next[gi] = pop_ok & (pop_tag == TW'(gi));
    end
  endgenerate

  always_comb begin
    sel_x = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (pick.id == client_id_t'(i)) begin
        sel_x = req_x[32*i +: 32];
      end
    end
  end

  isqrt_tag_fifo #(
    .WIDTH (TW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (transfer),
    .push_data (pick.id[TW-1:0]),
    .pop       (isqrt_y_vld),
    .pop_data  (pop_tag),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg     <= '0;
      isqrt_x_vld <= 1'b0;
      isqrt_x     <= '0;
      rsp_vld     <= '0;
      rsp_y       <= '0;
      err_orphan  <= 1'b0;
    end else begin
      isqrt_x_vld <= transfer;
      if (transfer) begin
        isqrt_x <= sel_x;
        ptr_reg <= ptr_next;
      end
      rsp_vld <= rsp_vld_next;
      if (pop_ok) begin
        rsp_y <= isqrt_y;
      end
      // A result with nothing outstanding is dropped and flagged; a push in
      // the same cycle cannot be its owner since the isqrt has not seen it.
      if (isqrt_y_vld && fifo_empty) begin
        err_orphan <= 1'b1;
      end
    end
  end

endmodule
